dense_layer_compute_mc: RTL

Multi-lane successor to the single-MAC dense layer engine, parametrised in lane count and maximum sizes.
- Computes NUM_LANES output channels per pass. One int8 input byte is broadcast to all lanes, and each lane receives its own int8 weight from one wide weight-ROM word.
- Read pipeline: one input element is consumed per cycle.
- Adds an optional ReLU and a valid/ready output stream with backpressure.
- Sits between tensor RAM / weight ROM / bias ROM and the requant/writeback stage.

---
 rtl/dense_pkg.sv | 24 ++
 rtl/dense_layer_compute_mc_lane_acc.sv | 29 ++
 rtl/dense_layer_compute_mc.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/dense_pkg.sv
// Shared types, FSM state encoding and index-width helper for the multi-lane dense layer engine.
package dense_pkg;

  typedef logic signed [7:0]  int8_t;
  typedef logic signed [31:0] int32_t;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_BIAS,
    STREAM,
    FLUSH,
    DRAIN,
    FINISH
  } dense_state_t;

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned ACC_W  = 32;

  // Index width for n entries, never below one bit so degenerate sizes still elaborate.
  function automatic int unsigned idx_bits(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/dense_layer_compute_mc_lane_acc.sv
// One output-channel accumulator: bias preload, then signed 8x8 MAC wrapping at 32 bits.
module dense_lane_acc
  import dense_pkg::*;
(
  input  logic   clk,
  input  logic   reset_n,
  input  logic   load_bias,
  input  int32_t bias_in,
  input  logic   acc_en,
  input  int8_t  in_a,
  input  int8_t  in_w,
  output int32_t acc_out
);

  logic signed [2*BYTE_W-1:0] prod;

  assign prod = in_a * in_w;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      acc_out <= '0;
    end else if (load_bias) begin
      acc_out <= bias_in;
    end else if (acc_en) begin
      acc_out <= acc_out + {{(ACC_W-2*BYTE_W){prod[2*BYTE_W-1]}}, prod};
    end
  end

endmodule

// File: rtl/dense_layer_compute_mc.sv
// Multi-lane dense layer engine: NUM_LANES channels per pass, broadcast input byte, wide weight word,
// optional ReLU and a valid/ready result stream.
module dense_layer_compute_mc
  import dense_pkg::*;
#(
  parameter int unsigned MAX_IN    = 256,
  parameter int unsigned MAX_OUT   = 64,
  parameter int unsigned NUM_LANES = 4
) (
  input  logic                                          clk,
  input  logic                                          reset_n,
  input  logic                                          start,
  input  logic [$clog2(MAX_IN+1)-1:0]                   input_size,
  input  logic [$clog2(MAX_OUT+1)-1:0]                  output_size,
  input  logic                                          relu_en,
  output logic [idx_bits(MAX_IN)-1:0]                   tensor_ram_addr,
  output logic                                          tensor_ram_re,
  input  logic [7:0]                                    tensor_ram_dout,
  output logic [idx_bits(MAX_IN*MAX_OUT/NUM_LANES)-1:0] weight_rom_addr,
  output logic                                          weight_rom_re,
  input  logic [NUM_LANES*8-1:0]                        weight_rom_dout,
  output logic [idx_bits(MAX_OUT/NUM_LANES)-1:0]        bias_rom_addr,
  output logic                                          bias_rom_re,
  input  logic [NUM_LANES*32-1:0]                       bias_rom_dout,
  output logic                                          out_valid,
  input  logic                                          out_ready,
  output logic [31:0]                                   out_data,
  output logic [idx_bits(MAX_OUT)-1:0]                  out_channel,
  output logic                                          busy,
  output logic                                          done
);

  localparam int unsigned IN_W    = $clog2(MAX_IN+1);
  localparam int unsigned OUT_W   = $clog2(MAX_OUT+1);
  localparam int unsigned ADDR_W  = idx_bits(MAX_IN);
  localparam int unsigned CH_W    = idx_bits(MAX_OUT);
  localparam int unsigned GRP_W   = idx_bits(MAX_OUT/NUM_LANES);
  localparam int unsigned WADDR_W = idx_bits(MAX_IN*MAX_OUT/NUM_LANES);
  localparam int unsigned LN_W    = idx_bits(NUM_LANES);

  dense_state_t     state, state_nx;
  logic [IN_W-1:0]  in_len, i_cnt, in_clamp;
  logic [OUT_W-1:0] out_len, out_clamp;
  logic             relu_q;
  logic [GRP_W-1:0] group;
  logic [LN_W-1:0]  lane;
  logic             rd_valid;
  logic             load_bias;
  logic [CH_W-1:0]  channel;
  logic             last_ch, last_lane;
  logic [WADDR_W-1:0] w_addr;
  int32_t           acc [NUM_LANES];
  int32_t           acc_sel;

  assign in_clamp  = (input_size > IN_W'(MAX_IN)) ? IN_W'(MAX_IN) : input_size;
  assign out_clamp = (output_size > OUT_W'(MAX_OUT)) ? OUT_W'(MAX_OUT) : output_size;

  assign channel   = CH_W'(group) * CH_W'(NUM_LANES) + CH_W'(lane);
  assign last_ch   = (OUT_W'(channel) == out_len - OUT_W'(1));
  assign last_lane = (lane == LN_W'(NUM_LANES-1)) || last_ch;
  assign w_addr    = WADDR_W'(group) * WADDR_W'(in_len) + WADDR_W'(i_cnt);
  assign acc_sel   = acc[lane];

  // Bias word arrives in the first STREAM cycle; products trail their reads by one cycle.
  assign load_bias = (state == STREAM) && (i_cnt == '0);

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    dense_lane_acc u_lane (
      .clk       (clk),
      .reset_n   (reset_n),
      .load_bias (load_bias),
      .bias_in   (bias_rom_dout[32*l +: 32]),
      .acc_en    (rd_valid),
      .in_a      (tensor_ram_dout),
      .in_w      (weight_rom_dout[8*l +: 8]),
      .acc_out   (acc[l])
    );
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state    <= IDLE;
      in_len   <= '0;
      out_len  <= '0;
      relu_q   <= 1'b0;
      group    <= '0;
      i_cnt    <= '0;
      lane     <= '0;
      rd_valid <= 1'b0;
    end else begin
      state    <= state_nx;
      rd_valid <= (state == STREAM);
      case (state)
        IDLE: begin
          if (start) begin
            in_len  <= in_clamp;
            out_len <= out_clamp;
            relu_q  <= relu_en;
            group   <= '0;
            i_cnt   <= '0;
            lane    <= '0;
          end
        end
        LOAD_BIAS: i_cnt <= '0;
        STREAM:    i_cnt <= i_cnt + IN_W'(1);
        FLUSH:     lane  <= '0;
        DRAIN: begin
          if (out_ready) begin
            if (last_lane) begin
              lane <= '0;
              if (!last_ch) group <= group + GRP_W'(1);
            end else begin
              lane <= lane + LN_W'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nx        = state;
    tensor_ram_addr = '0;
    tensor_ram_re   = 1'b0;
    weight_rom_addr = '0;
    weight_rom_re   = 1'b0;
    bias_rom_addr   = '0;
    bias_rom_re     = 1'b0;
    out_valid       = 1'b0;
    out_data        = '0;
    out_channel     = '0;
    busy            = (state != IDLE);
    done            = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nx = (in_clamp == '0 || out_clamp == '0) ? FINISH : LOAD_BIAS;
      end
      LOAD_BIAS: begin
        bias_rom_re   = 1'b1;
        bias_rom_addr = group;
        state_nx      = STREAM;
      end
      STREAM: begin
        tensor_ram_re   = 1'b1;
        weight_rom_re   = 1'b1;
        tensor_ram_addr = ADDR_W'(i_cnt);
        weight_rom_addr = w_addr;
        if (i_cnt == in_len - IN_W'(1)) state_nx = FLUSH;
      end
      FLUSH: state_nx = DRAIN;
      DRAIN: begin
        out_valid   = 1'b1;
        out_channel = channel;
        out_data    = (relu_q && acc_sel[31]) ? '0 : acc_sel;
        if (out_ready && last_lane) state_nx = last_ch ? FINISH : LOAD_BIAS;
      end
      FINISH: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule
